// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_pkg
// Description : Shared types and helpers for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    // Bit counter width; a floor of 1 keeps the counter legal at the minimum width.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_sub.sv
`default_nettype none
// ============================================================================
// Module      : full_sub
// Description : 1-bit full subtractor (a - b - cin).
// Revision    : 1.0 - initial release
// ============================================================================
module full_sub (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic diff,
    output logic barrow
);

    assign diff   = a ^ b ^ cin;
    assign barrow = (~a & b) | (~a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub
// Description : Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_sh_a;
    logic [WIDTH-1:0]   r_sh_b;
    logic [WIDTH-1:0]   r_sh_d;
    logic               r_brw;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;

    logic               w_diff_bit;
    logic               w_borrow;

    full_sub u_full_sub (
        .a      (r_sh_a[0]),
        .b      (r_sh_b[0]),
        .cin    (r_brw),
        .diff   (w_diff_bit),
        .barrow (w_borrow)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_sh_d  <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sh_a  <= a;
                        r_sh_b  <= b;
                        r_brw   <= bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_brw  <= w_borrow;
                    r_sh_d <= {w_diff_bit, r_sh_d[WIDTH-1:1]};
                    r_sh_a <= r_sh_a >> 1;
                    r_sh_b <= r_sh_b >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                    // Last bit: publish the fully assembled result in one step.
                    if (r_cnt == c_LAST) begin
                        r_diff  <= {w_diff_bit, r_sh_d[WIDTH-1:1]};
                        r_bout  <= w_borrow;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub
// Description : Self-checking bench for serial_sub at WIDTH=8 and WIDTH=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       start3 = 1'b0, bin3 = 1'b0, busy3, done3, bout3;
    logic [2:0] a3 = '0, b3 = '0, diff3;

    int nchk = 0;
    int nerr = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_sub #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .diff(diff3), .bout(bout3)
    );

    // Reference: {bout,diff} = (a - b - bin) mod 2^(w+1)
    function automatic longint ref_sub(input int w, input longint a, input longint b, input bit bi);
        longint m;
        m = (longint'(1) << (w + 1)) - 1;
        return (a - b - longint'(bi)) & m;
    endfunction

    // Cycle-level model: an accepted op yields its result exactly w cycles later.
    typedef struct {
        bit     busy;
        bit     done;
        longint diff;
        bit     bout;
        int     rem;
        longint res;
    } mdl_t;

    function automatic mdl_t mstep(input mdl_t s, input int w, input bit rstn, input bit st,
                                   input longint a, input longint b, input bit bi);
        mdl_t n;
        n = s;
        if (!rstn) begin
            n = '{default: 0};
            return n;
        end
        n.done = 1'b0;
        if (s.busy) begin
            n.rem = s.rem - 1;
            if (n.rem == 0) begin
                n.busy = 1'b0;
                n.done = 1'b1;
                n.diff = s.res & ((longint'(1) << w) - 1);
                n.bout = bit'((s.res >> w) & 1);
            end
        end else if (st) begin
            n.res  = ref_sub(w, a, b, bi);
            n.rem  = w;
            n.busy = 1'b1;
        end
        return n;
    endfunction

    mdl_t m8 = '{default: 0};
    mdl_t m3 = '{default: 0};

    always @(posedge clk) begin
        m8 = mstep(m8, 8, rst_n, start8, longint'(a8), longint'(b8), bin8);
        m3 = mstep(m3, 3, rst_n, start3, longint'(a3), longint'(b3), bin3);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy8", longint'(busy8), longint'(m8.busy));
            chk("done8", longint'(done8), longint'(m8.done));
            chk("diff8", longint'(diff8), m8.diff);
            chk("bout8", longint'(bout8), longint'(m8.bout));
            chk("busy3", longint'(busy3), longint'(m3.busy));
            chk("done3", longint'(done3), longint'(m3.done));
            chk("diff3", longint'(diff3), m3.diff);
            chk("bout3", longint'(bout3), longint'(m3.bout));
        end
    end

    // One operation on the selected instance; returns observed result.
    task automatic op(input int sel, input longint a, input longint b, input bit bi,
                      output longint od, output bit ob);
        int  w;
        int  cyc;
        bit  seen;
        w = (sel == 8) ? 8 : 3;
        @(negedge clk);
        if (sel == 8) begin start8 = 1'b1; a8 = 8'(a); b8 = 8'(b); bin8 = bi; end
        else          begin start3 = 1'b1; a3 = 3'(a); b3 = 3'(b); bin3 = bi; end
        seen = 1'b0;
        od   = 0;
        ob   = 1'b0;
        for (cyc = 1; cyc <= 4 * w + 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                // Scramble operands after acceptance; the result must not move.
                if (sel == 8) begin start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); end
                else          begin start3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom); bin3 = 1'($urandom); end
            end
            if ((sel == 8) ? done8 : done3) begin
                seen = 1'b1;
                od   = (sel == 8) ? longint'(diff8) : longint'(diff3);
                ob   = (sel == 8) ? bout8 : bout3;
                break;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        else       chk("latency", cyc, w + 1);
    endtask

    initial begin
        longint d;
        bit     bo;
        int     ndone;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_busy8", busy8, 0);
        chk("rst_diff8", diff8, 0);
        rst_n = 1'b1;

        // Directed vectors with hand-computed results
        op(8, 'h5A, 'h3C, 0, d, bo); chk("t1_diff", d, 'h1E); chk("t1_bout", bo, 0);
        op(8, 'h00, 'h01, 0, d, bo); chk("t2a_diff", d, 'hFF); chk("t2a_bout", bo, 1);
        op(8, 'h00, 'hFF, 1, d, bo); chk("t2b_diff", d, 'h00); chk("t2b_bout", bo, 1);
        op(8, 'h80, 'h7F, 1, d, bo); chk("t3a_diff", d, 'h00); chk("t3a_bout", bo, 0);
        op(8, 'hFF, 'h00, 0, d, bo); chk("t3b_diff", d, 'hFF); chk("t3b_bout", bo, 0);
        op(3, 3, 5, 0, d, bo);       chk("w3_diff", d, 6);     chk("w3_bout", bo, 1);
        op(3, 7, 0, 1, d, bo);       chk("w3b_diff", d, 6);    chk("w3b_bout", bo, 0);

        // start held high with fresh operands every cycle
        @(negedge clk);
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        ndone = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (done8) ndone++;
            if (i < 45) begin a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); end
            else        start8 = 1'b0;
        end
        chk("t4_done_count", ndone, 5);

        // Reset mid-operation when the bit counter reads 4
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) start8 = 1'b0;
        end
        chk("t5_busy_before", busy8, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_busy", busy8, 0);
        chk("t5_done", done8, 0);
        chk("t5_diff", diff8, 0);
        chk("t5_bout", bout8, 0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("t5_no_done", ndone, 0);
        op(8, 'h33, 'h11, 0, d, bo); chk("t5_after_diff", d, 'h22); chk("t5_after_bout", bo, 0);

        // Random sweep on both widths
        for (int i = 0; i < 500; i++) begin
            longint ra, rb, r;
            bit     rbi;
            ra = longint'($urandom_range(0, 255));
            rb = longint'($urandom_range(0, 255));
            rbi = 1'($urandom);
            op(8, ra, rb, rbi, d, bo);
            r = ref_sub(8, ra, rb, rbi);
            chk("rnd8", {bo, d[7:0]}, r);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 500; i++) begin
            longint ra, rb, r;
            bit     rbi;
            ra = longint'($urandom_range(0, 7));
            rb = longint'($urandom_range(0, 7));
            rbi = 1'($urandom);
            op(3, ra, rb, rbi, d, bo);
            r = ref_sub(3, ra, rb, rbi);
            chk("rnd3", {bo, d[2:0]}, r);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
